// File: rtl/bridge_pkg.sv
// Shared types and helpers for the bridge datapath blocks.
package bridge_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    localparam int DATA_W_DEF = 8;

    // Bits needed to hold values 0..value-1 (never less than one bit).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching
// cyclically upward from the port after last_grant.
module rr_pick
    import bridge_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last_grant,
    output logic                 found,
    output logic [PORT_W-1:0]    pick
);

    // Walk offsets 1..NUM_PORTS so last_grant itself is considered last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!found && req[i] && (i == (int'(last_grant) + k) % NUM_PORTS)) begin
                    found = 1'b1;
                    pick  = PORT_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read arbiter draining several show-ahead byte FIFOs into
// one egress stream; each byte is tagged with its source port.
module fifo_rr_arbiter
    import bridge_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int MAX_BURST = 16,
    localparam int PORT_W    = clog2(NUM_PORTS),
    localparam int CNT_W     = clog2(MAX_BURST + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_PORTS-1:0]        fifo_empty,
    input  logic [NUM_PORTS*DATA_W-1:0] fifo_data,
    output logic [NUM_PORTS-1:0]        fifo_read,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    output logic [PORT_W-1:0]           out_port,
    output logic                        busy
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_e          state;
    logic [PORT_W-1:0]   gnt;
    logic [PORT_W-1:0]   last_grant;
    logic [CNT_W-1:0]    cnt;
    logic                pick_found;
    logic [PORT_W-1:0]   pick_port;
    logic                gnt_empty;
    logic [DATA_W-1:0]   gnt_data;
    logic                rd_en;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req        (~fifo_empty),
        .last_grant (last_grant),
        .found      (pick_found),
        .pick       (pick_port)
    );

    assign gnt_empty = fifo_empty[gnt];
    assign gnt_data  = fifo_data[gnt*DATA_W +: DATA_W];

    // An empty FIFO or a dropped enable blocks the read even with the sink ready.
    assign rd_en = (state == ARB_GRANT) && enable && !gnt_empty && out_ready && (cnt < CNT_MAX);

    assign busy = (state != ARB_IDLE);

    // Drive the read strobe only to the granted port.
    always_comb begin
        fifo_read = '0;
        if (rd_en) fifo_read[gnt] = 1'b1;
    end

    // Grant FSM plus the one-cycle read-to-egress register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            gnt        <= '0;
            last_grant <= PORT_W'(NUM_PORTS - 1);
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_port   <= '0;
        end else begin
            // egress stage: byte read this cycle appears next cycle
            out_valid <= rd_en;
            if (rd_en) begin
                out_data <= gnt_data;
                out_port <= gnt;
            end

            case (state)
                ARB_IDLE: begin
                    if (enable && pick_found) begin
                        gnt   <= pick_port;
                        cnt   <= '0;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!enable || gnt_empty) begin
                        state <= ARB_GAP;
                    end else if (rd_en) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= ARB_GAP;
                    end
                end
                ARB_GAP: begin
                    // dead cycle lets the last byte emerge before another port is read
                    last_grant <= gnt;
                    state      <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter with a FIFO model and an in-order
// per-port scoreboard on the egress stream.
module tb_fifo_rr_arbiter;

    localparam int NP = 2;
    localparam int DW = 8;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NP-1:0]     fifo_empty;
    logic [NP*DW-1:0]  fifo_data;
    logic [NP-1:0]     fifo_read;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic [0:0]        out_port;
    logic              busy;

    logic [7:0] mem [NP][64];
    int         wr [NP];
    int         rd [NP];

    int n_chk, n_pass;
    int ob [NP];
    int nrd [NP];
    int nout [NP];
    logic [NP-1:0] prev_rd;
    int runs [$];

    logic [NP-1:0] s_read, s_empty;
    logic          s_valid, s_busy;
    logic [7:0]    s_data;
    logic [0:0]    s_port;

    fifo_rr_arbiter #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_port   (out_port),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model: head byte visible, empty reflects pops already taken.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i]          = (wr[i] == rd[i]);
            fifo_data[i*DW +: DW]  = mem[i][rd[i] % 64];
        end
    end

    // Pop on each strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++)
            if (fifo_read[i]) rd[i] <= rd[i] + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input int p, input logic [7:0] b);
        mem[p][wr[p] % 64] = b;
        wr[p] = wr[p] + 1;
    endtask

    // One clock: sample at negedge, run protocol/scoreboard checks, return just after posedge.
    task automatic cyc();
        @(negedge clk);
        s_read  = fifo_read;
        s_empty = fifo_empty;
        s_valid = out_valid;
        s_busy  = busy;
        s_data  = out_data;
        s_port  = out_port;
        check("rd_onehot", 32'($onehot0(fifo_read)), 32'd1);
        check("rd_while_empty", 32'(fifo_read & fifo_empty), 32'd0);
        check("rd_port_switch", 32'(prev_rd != 0 && fifo_read != 0 && fifo_read != prev_rd), 32'd0);
        if (fifo_read != 0) begin
            if (prev_rd == 0) runs.push_back((fifo_read[1] ? 100 : 0) + 1);
            else runs[runs.size()-1] = runs[runs.size()-1] + 1;
        end
        for (int i = 0; i < NP; i++)
            if (fifo_read[i]) nrd[i]++;
        if (out_valid) begin
            check("out_data_order", 32'(out_data), 32'(mem[out_port][ob[out_port] % 64]));
            ob[out_port]   = ob[out_port] + 1;
            nout[out_port] = nout[out_port] + 1;
        end
        prev_rd = fifo_read;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int limit);
        bit done;
        done = 1'b0;
        for (int n = 0; n < limit && !done; n++) begin
            cyc();
            done = (s_busy == 1'b0) && (s_empty == '1) && (s_valid == 1'b0);
        end
        check(tag, 32'(done), 32'd1);
    endtask

    int exp_rd [7] = '{0, 2, 2, 2, 0, 0, 0};
    int exp_vl [7] = '{0, 0, 1, 1, 1, 0, 0};
    int exp_by [7] = '{0, 1, 1, 1, 1, 1, 0};
    int exp_dt [7] = '{0, 0, 'hA1, 'hA2, 'hA3, 0, 0};
    int exp_runs [6] = '{4, 104, 4, 104, 2, 102};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, o0, o1;
        rst = 1'b1; enable = 1'b1; out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state, then a 3-byte grant on port 1.
        push(1, 8'hA1); push(1, 8'hA2); push(1, 8'hA3);
        cyc();
        check("rst_read", 32'(s_read), 32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_data", 32'(s_data), 32'd0);
        check("rst_port", 32'(s_port), 32'd0);
        for (int c = 1; c < 7; c++) begin
            cyc();
            check($sformatf("t1_read_c%0d", c), 32'(s_read), exp_rd[c]);
            check($sformatf("t1_valid_c%0d", c), 32'(s_valid), exp_vl[c]);
            check($sformatf("t1_busy_c%0d", c), 32'(s_busy), exp_by[c]);
            if (s_valid) begin
                check($sformatf("t1_data_c%0d", c), 32'(s_data), exp_dt[c]);
                check($sformatf("t1_port_c%0d", c), 32'(s_port), 32'd1);
            end
        end

        // Burst limit: alternating 4-byte grants from a fresh reset.
        rst = 1'b1; cyc(); rst = 1'b0;
        runs.delete();
        o0 = nout[0]; o1 = nout[1];
        for (int i = 0; i < 10; i++) begin
            push(0, 8'(i));
            push(1, 8'(8'h10 + i));
        end
        drain("t2_drain", 80);
        check("t2_nruns", 32'(runs.size()), 32'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("t2_run%0d", k), (k < runs.size()) ? runs[k] : -1, exp_runs[k]);
        check("t2_bytes_p0", 32'(nout[0] - o0), 32'd10);
        check("t2_bytes_p1", 32'(nout[1] - o1), 32'd10);

        // Backpressure: out_ready low in grant cycles 3..5.
        r0 = nrd[0]; o0 = nout[0];
        for (int i = 0; i < 6; i++) push(0, 8'(8'h20 + i));
        cyc(); check("t3_idle_read", 32'(s_read), 32'd0);
        cyc(); check("t3_g1_read", 32'(s_read), 32'd1);
        cyc(); check("t3_g2_read", 32'(s_read), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_stall_read", 32'(s_read), 32'd0);
            check("t3_stall_busy", 32'(s_busy), 32'd1);
        end
        out_ready = 1'b1;
        cyc(); check("t3_g6_read", 32'(s_read), 32'd1);
        cyc(); check("t3_g7_read", 32'(s_read), 32'd1);
        cyc();
        check("t3_gap_read", 32'(s_read), 32'd0);
        check("t3_gap_busy", 32'(s_busy), 32'd1);
        check("t3_gap_valid", 32'(s_valid), 32'd1);
        cyc(); check("t3_idle_busy", 32'(s_busy), 32'd0);
        drain("t3_drain", 40);
        check("t3_reads", 32'(nrd[0] - r0), 32'd6);
        check("t3_bytes", 32'(nout[0] - o0), 32'd6);

        // Empty mid-burst: only 2 bytes on port 1.
        runs.delete();
        o1 = nout[1];
        push(1, 8'h30); push(1, 8'h31);
        drain("t4_drain", 40);
        check("t4_nruns", 32'(runs.size()), 32'd1);
        check("t4_run", (runs.size() > 0) ? runs[0] : -1, 32'd102);
        check("t4_bytes", 32'(nout[1] - o1), 32'd2);

        // Enable drop after the third read.
        r1 = nrd[1]; o1 = nout[1];
        for (int i = 0; i < 8; i++) push(1, 8'(8'h40 + i));
        cyc(); check("t5_idle_read", 32'(s_read), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); check("t5_read", 32'(s_read), 32'd2);
        end
        enable = 1'b0;
        cyc();
        check("t5_drop_read", 32'(s_read), 32'd0);
        check("t5_drop_valid", 32'(s_valid), 32'd1);
        check("t5_drop_data", 32'(s_data), 32'h42);
        check("t5_drop_busy", 32'(s_busy), 32'd1);
        cyc();
        check("t5_gap_busy", 32'(s_busy), 32'd1);
        check("t5_gap_valid", 32'(s_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t5_off_busy", 32'(s_busy), 32'd0);
            check("t5_off_read", 32'(s_read), 32'd0);
        end
        check("t5_partial_bytes", 32'(nout[1] - o1), 32'd3);
        enable = 1'b1;
        drain("t5_drain", 40);
        check("t5_reads", 32'(nrd[1] - r1), 32'd8);
        check("t5_bytes", 32'(nout[1] - o1), 32'd8);

        // Reset during the second read of a 5-byte grant on port 0.
        o0 = nout[0]; o1 = nout[1];
        for (int i = 0; i < 5; i++) push(0, 8'(8'h50 + i));
        cyc(); check("t6_idle_read", 32'(s_read), 32'd0);
        cyc(); check("t6_g1_read", 32'(s_read), 32'd1);
        rst = 1'b1;
        push(1, 8'h60); push(1, 8'h61);
        cyc();
        check("t6_g2_read", 32'(s_read), 32'd1);
        check("t6_g2_data", 32'(s_data), 32'h50);
        rst = 1'b0;
        ob[0] = ob[0] + 1;
        cyc();
        check("t6_rst_valid", 32'(s_valid), 32'd0);
        check("t6_rst_busy", 32'(s_busy), 32'd0);
        check("t6_rst_read", 32'(s_read), 32'd0);
        cyc(); check("t6_prio_read", 32'(s_read), 32'd1);
        drain("t6_drain", 40);
        check("t6_bytes_p0", 32'(nout[0] - o0), 32'd4);
        check("t6_bytes_p1", 32'(nout[1] - o1), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
